// File: rtl/periodic_serial_tx.sv
// Periodic serial transmitter: sends a latched message (with optional parity)
// as a bit stream. Frames are separated by a programmable stand-by gap.
module periodic_serial_tx #(
  parameter int MSG_W     = 4,
  parameter int SB_W      = 4,
  parameter bit MSB_FIRST = 1'b0,
  parameter int PARITY    = 0,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             mode,
  input  logic             start,
  input  logic [MSG_W-1:0] msg,
  input  logic [SB_W-1:0]  SB,
  output logic             state_send,
  output logic             state_out,
  output logic             frame_done,
  output logic             busy
);

  localparam bit PAR_EN = (PARITY == 1) || (PARITY == 2);
  localparam int F      = PAR_EN ? MSG_W + 1 : MSG_W;
  localparam int CNT_W  = $clog2(F + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(F - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state_q, state_d;
  logic [MSG_W:0]   shreg_q, shreg_d, frame_w;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SB_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic             state_send_q, state_send_d;
  logic             state_out_q, state_out_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             go_on;

  assign go_on = EN && !mode;

  // Frame in transmission order: bit 0 goes out first, parity sits on top.
  always_comb begin
    frame_w = '0;
    for (int i = 0; i < MSG_W; i++) begin
      frame_w[i] = MSB_FIRST ? msg[MSG_W-1-i] : msg[i];
    end
    if (PARITY == 1) begin
      frame_w[MSG_W] = ^msg;
    end else if (PARITY == 2) begin
      frame_w[MSG_W] = ~^msg;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (EN && (!mode || start)) begin
          state_d   = SEND;
          shreg_d   = frame_w;
          bit_cnt_d = '0;
        end
      end
      SEND: begin
        if (bit_cnt_q == LAST) begin
          if (SB != '0) begin
            state_d   = GAP;
            gap_cnt_d = SB;
          end else if (go_on) begin
            state_d   = SEND;
            shreg_d   = frame_w;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        // Count down to 1 rather than 0 so an all-ones SB never wraps.
        if (gap_cnt_q == SB_W'(1)) begin
          gap_cnt_d = '0;
          if (go_on) begin
            state_d   = SEND;
            shreg_d   = frame_w;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - SB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they appear as flops.
    state_send_d = (state_d == SEND);
    state_out_d  = (state_d == SEND) ? shreg_d[0] : IDLE_LVL;
    frame_done_d = (state_d == SEND) && (bit_cnt_d == LAST);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      state_send_q <= 1'b0;
      state_out_q  <= IDLE_LVL;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      state_send_q <= state_send_d;
      state_out_q  <= state_out_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign state_send = state_send_q;
  assign state_out  = state_out_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_periodic_serial_tx.sv
// Scoreboard bench for periodic_serial_tx: two instances (default and 8-bit
// MSB-first odd-parity idle-high) driven by shared stimulus.
module tb_periodic_serial_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       mode = 1'b0;
  logic       start = 1'b0;
  logic [3:0] msg_a = 4'd0;
  logic [7:0] msg_b = 8'd0;
  logic [3:0] SB = 4'd0;

  logic send_a, out_a, done_a, busy_a;
  logic send_b, out_b, done_b, busy_b;

  always #5 CLK = ~CLK;

  periodic_serial_tx dut_a (
    .CLK(CLK), .RST(RST), .EN(EN), .mode(mode), .start(start),
    .msg(msg_a), .SB(SB),
    .state_send(send_a), .state_out(out_a), .frame_done(done_a), .busy(busy_a)
  );

  periodic_serial_tx #(
    .MSG_W(8), .SB_W(4), .MSB_FIRST(1'b1), .PARITY(2), .IDLE_LVL(1'b1)
  ) dut_b (
    .CLK(CLK), .RST(RST), .EN(EN), .mode(mode), .start(start),
    .msg(msg_b), .SB(SB),
    .state_send(send_b), .state_out(out_b), .frame_done(done_b), .busy(busy_b)
  );

  // Entry layout: {busy, frame_done, state_out, state_send}
  typedef logic [3:0] ent_t;

  ent_t sched [2][$];
  ent_t exp_q [2][$];
  bit   need_gap [2] = '{1'b0, 1'b0};
  bit   was_idle [2] = '{1'b1, 1'b1};
  int   dut_w    [2] = '{4, 8};
  bit   dut_msbf [2] = '{1'b0, 1'b1};
  int   dut_par  [2] = '{0, 2};
  bit   dut_idle [2] = '{1'b0, 1'b1};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: schedules whole frames and gaps as lists of future cycles.
  task automatic model_step(input int w, input logic [31:0] m);
    ent_t e;
    int   ones;
    bit   go;
    bit   b;
    bit   p;
    if (RST) begin
      sched[w].delete();
      need_gap[w] = 1'b0;
      e = {1'b0, 1'b0, dut_idle[w], 1'b0};
    end else begin
      if (sched[w].size() == 0) begin
        if (need_gap[w] && SB != 4'd0) begin
          for (int i = 0; i < int'(SB); i++)
            sched[w].push_back({1'b1, 1'b0, dut_idle[w], 1'b0});
          need_gap[w] = 1'b0;
        end else begin
          go = EN && (!mode || (was_idle[w] && start));
          need_gap[w] = 1'b0;
          if (go) begin
            ones = 0;
            for (int i = 0; i < dut_w[w]; i++) begin
              b = dut_msbf[w] ? m[dut_w[w]-1-i] : m[i];
              ones += int'(b);
              sched[w].push_back({1'b1, (i == dut_w[w]-1) && (dut_par[w] == 0), b, 1'b1});
            end
            if (dut_par[w] == 1) begin
              p = (ones % 2) == 1;
              sched[w].push_back({1'b1, 1'b1, p, 1'b1});
            end else if (dut_par[w] == 2) begin
              p = (ones % 2) == 0;
              sched[w].push_back({1'b1, 1'b1, p, 1'b1});
            end
            need_gap[w] = 1'b1;
          end
        end
      end
      if (sched[w].size() == 0) e = {1'b0, 1'b0, dut_idle[w], 1'b0};
      else                      e = sched[w].pop_front();
    end
    was_idle[w] = !e[3];
    exp_q[w].push_back(e);
  endtask

  always @(posedge CLK) begin
    model_step(0, {28'd0, msg_a});
    model_step(1, {24'd0, msg_b});
  end

  task automatic checkOutput(input string name, input ent_t act, input ent_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got {busy,done,out,send}=%b expected %b",
               name, $time, act, exp);
    end
  endtask

  // Monitor: pops one expected entry per cycle for each instance.
  always @(negedge CLK) begin
    ent_t e;
    if (exp_q[0].size() > 0) begin
      e = exp_q[0].pop_front();
      checkOutput("dut_a", {busy_a, done_a, out_a, send_a}, e);
    end
    if (exp_q[1].size() > 0) begin
      e = exp_q[1].pop_front();
      checkOutput("dut_b", {busy_b, done_b, out_b, send_b}, e);
    end
  end

  task automatic applyStimulus(input bit rst, input bit en, input bit md, input bit st,
                               input logic [3:0] ma, input logic [7:0] mb,
                               input logic [3:0] sb);
    @(negedge CLK);
    RST   = rst;
    EN    = en;
    mode  = md;
    start = st;
    msg_a = ma;
    msg_b = mb;
    SB    = sb;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int r;
    applyStimulus(1, 0, 0, 0, 4'd0, 8'd0, 4'd0);
    hold(2);

    // Continuous frames with a 3-cycle gap.
    applyStimulus(0, 1, 0, 0, 4'b1011, 8'hA5, 4'd3);
    hold(30);

    // Back-to-back frames, no gap.
    applyStimulus(0, 1, 0, 0, 4'b1011, 8'hA5, 4'd0);
    hold(30);

    // Let it stop, then single-shot with a retrigger while busy.
    applyStimulus(0, 0, 1, 0, 4'b0110, 8'h3C, 4'd2);
    hold(20);
    applyStimulus(0, 1, 1, 1, 4'b0110, 8'h3C, 4'd2);
    applyStimulus(0, 1, 1, 0, 4'b0110, 8'h3C, 4'd2);
    hold(2);
    applyStimulus(0, 1, 1, 1, 4'b1001, 8'h81, 4'd2);
    applyStimulus(0, 1, 1, 0, 4'b1001, 8'h81, 4'd2);
    hold(20);

    // EN dropped mid-frame.
    applyStimulus(0, 1, 0, 0, 4'b1101, 8'h5A, 4'd3);
    hold(2);
    applyStimulus(0, 0, 0, 0, 4'b1101, 8'h5A, 4'd3);
    hold(25);

    // Reset mid-frame, then restart.
    applyStimulus(0, 1, 0, 0, 4'b0111, 8'hF0, 4'd2);
    hold(3);
    applyStimulus(1, 1, 0, 0, 4'b0111, 8'hF0, 4'd2);
    applyStimulus(0, 1, 0, 0, 4'b0111, 8'hF0, 4'd2);
    hold(20);

    // Maximum gap with msg churning every cycle.
    for (int i = 0; i < 80; i++)
      applyStimulus(0, 1, 0, 0, 4'($urandom), 8'($urandom), 4'hF);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      applyStimulus(r < 2, ($urandom_range(0, 9) != 0), (i / 40) % 2 == 1,
                    ($urandom_range(0, 7) == 0), 4'($urandom), 8'($urandom),
                    4'($urandom_range(0, 15)));
    end

    applyStimulus(0, 0, 0, 0, 4'd0, 8'd0, 4'd0);
    hold(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/periodic_serial_tx.md
PERIODIC_SERIAL_TX -- requirements
Module: periodic_serial_tx

Interface
REQ-001 Parameter MSG_W, default 4, message width in bits (1..32).
REQ-002 Parameter SB_W, default 4, width of the stand-by gap count.
REQ-003 Parameter MSB_FIRST, default 0, bit order: 0 sends msg[0] first, 1 sends msg[MSG_W-1] first.
REQ-004 Parameter PARITY, default 0, frame parity: 0 none, 1 even, 2 odd; any other value is treated as 0.
REQ-005 Parameter IDLE_LVL, default 0, state_out level when no bit is being sent.
REQ-006 CLK  input  1  single clock; all state changes on the rising edge.
REQ-007 RST  input  1  reset, synchronous and active-high.
REQ-008 EN  input  1  enable; a new frame starts only while EN=1.
REQ-009 mode  input  1  0 continuous (frames repeat, separated by the gap); 1 single-shot (one frame per start).
REQ-010 start  input  1  single-shot trigger, sampled only in IDLE with mode=1.
REQ-011 msg  input  MSG_W  message to transmit.
REQ-012 SB  input  SB_W  stand-by gap length in clock cycles.
REQ-013 state_send  output  1  high on every cycle that carries a frame bit.
REQ-014 state_out  output  1  serial data channel.
REQ-015 frame_done  output  1  one-cycle pulse on the last bit cycle of each frame.
REQ-016 busy  output  1  high in SEND and GAP.

Function
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-018 FSM states SHALL be IDLE, SEND and GAP.
REQ-019 Frame length F SHALL be MSG_W+1 when PARITY is 1 or 2, otherwise MSG_W.
REQ-020 IDLE->SEND SHALL occur on an edge where EN=1 and either mode=0, or mode=1 with start=1.
REQ-021 The first bit SHALL appear on the cycle after the qualifying edge, so latency is 1 cycle.
REQ-022 msg SHALL be latched on the IDLE->SEND or GAP->SEND edge; later msg changes SHALL NOT affect the frame in flight.
REQ-023 SEND SHALL last exactly F cycles: state_send=1, data bits in MSB_FIRST order, parity bit last when enabled.
REQ-024 Even parity SHALL make the total count of ones in data plus parity even; odd parity SHALL make it odd.
REQ-025 frame_done SHALL pulse on the F-th SEND cycle only.
REQ-026 SB SHALL be latched on the SEND->GAP edge.
REQ-027 GAP SHALL last exactly SB cycles: state_send=0, state_out=IDLE_LVL.
REQ-028 SB=0 SHALL skip GAP, so the next frame's first bit directly follows the previous frame's last bit.
REQ-029 At the end of GAP, or at the end of SEND when SB=0, the FSM SHALL go to SEND if EN=1 and mode=0, otherwise to IDLE.
REQ-030 A single-shot frame SHALL still serve its full gap before IDLE; start SHALL be ignored while busy=1.
REQ-031 Dropping EN mid-frame or mid-gap SHALL NOT truncate either; the block SHALL stop at the next decision point (REQ-029).
REQ-032 Changing mode mid-frame SHALL take effect only at the next decision point.
REQ-033 The gap counter SHALL be SB_W bits wide and SHALL NOT wrap, so SB=2^SB_W-1 gives exactly that many gap cycles.

Reset
REQ-034 While RST=1, the next edge SHALL force IDLE, state_send=0, state_out=IDLE_LVL, frame_done=0, busy=0 and clear the counters.
REQ-035 RST SHALL take priority over all inputs, including mid-frame, where it abandons the frame immediately with no frame_done.
REQ-036 After RST falls, a frame SHALL start no earlier than the first edge at which RST=0 and the REQ-020 conditions hold.

Verification
REQ-037 Defaults, mode=0, EN=1, msg=4'b1011, SB=3 -> state_out repeats 1,1,0,1 then 0,0,0; state_send high 4 of every 7 cycles; frame_done on each 4th bit.
REQ-038 MSG_W=8, MSB_FIRST=1, PARITY=2, msg=8'hA5, SB=0 -> back-to-back 9-bit frames 1,0,1,0,0,1,0,1,1 with no idle cycle between frames.
REQ-039 mode=1, start pulsed once, SB=2 -> one frame, busy high for 6 cycles, then IDLE; a second start during busy is ignored.
REQ-040 EN dropped on bit 2 of a continuous frame -> that frame and its gap complete, then IDLE; no further state_send.
REQ-041 RST asserted on bit 3 -> next edge: all outputs at reset values, no frame_done; a frame restarts the cycle after RST falls with EN=1.
REQ-042 SB=4'hF, msg changed during SEND -> gap is exactly 15 cycles and the in-flight frame uses the latched msg.
